// File: rtl/nbody_pkg.sv
// Purpose: shared types and helpers for the n-body force datapath.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
// Contents: FORCE_W, force_t, state_t (accumulator FSM), sat16().
package nbody_pkg;

  localparam int FORCE_W  = 16;
  // sat16 takes a fixed wide input; callers sign-extend their
  // accumulator (ACC_W <= SAT_IN_W) with a size cast.
  localparam int SAT_IN_W = 32;

  typedef logic signed [FORCE_W-1:0] force_t;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    ACCUM,
    FLUSH,
    PUBLISH
  } state_t;

  // Clamp a wide signed value into the 16-bit force range.
  function automatic force_t sat16(input logic signed [SAT_IN_W-1:0] v);
    if (v > 32'sd32767) begin
      return 16'sh7FFF;
    end else if (v < -32'sd32768) begin
      return 16'sh8000;
    end
    return v[FORCE_W-1:0];
  endfunction

endpackage

// File: rtl/sat_add_acc.sv
// Purpose: signed ACC_W accumulate of one 16-bit contribution, clamped to ACC_W range.
// Latency: combinational (0 cycles).
// Backpressure: none; pure function of its inputs.
// Ports: acc_cur (current sum), addend (signed force), acc_nxt (saturated sum).
module sat_add_acc
  import nbody_pkg::*;
#(
  parameter int ACC_W = 20
) (
  input  logic signed [ACC_W-1:0]   acc_cur,
  input  logic signed [FORCE_W-1:0] addend,
  output logic signed [ACC_W-1:0]   acc_nxt
);

  // One guard bit is enough: the sum of an ACC_W and a 16-bit signed
  // value (ACC_W >= 16) always fits in ACC_W+1 bits.
  logic signed [ACC_W:0] sum;

  assign sum = {acc_cur[ACC_W-1], acc_cur}
             + {{(ACC_W+1-FORCE_W){addend[FORCE_W-1]}}, addend};

  // Guard bit disagreeing with the ACC_W sign bit means overflow; the
  // guard bit then carries the true sign and picks the rail.
  always_comb begin
    acc_nxt = sum[ACC_W-1:0];
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      acc_nxt = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                           : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/force_accumulator.sv
// Purpose: per-body sum of force contributions, flushed saturated to the frame output buffer.
// Latency: START->CLEAR 1 cycle; IN_LAST accept->first WR_EN 1 cycle; last WR_EN->FRAME_VALID 1 cycle.
// Backpressure: IN_READY high only in ACCUM; buffer writes are never stalled.
// Ports: START/IN_* contribution stream in; CLEAR/WR_*/FORCE_* buffer writes out;
//        FRAME_VALID held until BUF_DONE; BUSY outside IDLE; ERR sticky bad index.
module force_accumulator
  import nbody_pkg::*;
#(
  parameter int N        = 4,
  parameter int IDX_BITS = $clog2(N),
  parameter int ACC_W    = 20
) (
  input  logic                CLK_IN,
  input  logic                RESET_IN,
  input  logic                START,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [IDX_BITS-1:0] IN_IDX,
  input  logic [15:0]         IN_FX,
  input  logic [15:0]         IN_FY,
  input  logic                IN_LAST,
  output logic                CLEAR,
  output logic                WR_EN,
  output logic [IDX_BITS-1:0] WR_IDX,
  output logic [15:0]         FORCE_X,
  output logic [15:0]         FORCE_Y,
  output logic                FRAME_VALID,
  input  logic                BUF_DONE,
  output logic                BUSY,
  output logic                ERR
);

  localparam logic [IDX_BITS:0]   N_EXT    = (IDX_BITS+1)'(N);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(N-1);

  state_t state, state_nxt;

  logic signed [ACC_W-1:0] acc_x [N];
  logic signed [ACC_W-1:0] acc_y [N];

  logic [IDX_BITS-1:0]     flush_cnt;
  logic [IDX_BITS-1:0]     fidx;
  logic                    accept, idx_ok, fidx_ok;
  logic                    clear_d, wr_en_d, frame_valid_d;
  logic signed [ACC_W-1:0] cur_x, cur_y, sum_x, sum_y, fwd_x, fwd_y;

  assign IN_READY = (state == ACCUM);
  assign accept   = IN_VALID && IN_READY;
  assign idx_ok   = ({1'b0, IN_IDX} < N_EXT);

  assign cur_x = idx_ok ? acc_x[IN_IDX] : '0;
  assign cur_y = idx_ok ? acc_y[IN_IDX] : '0;

  sat_add_acc #(.ACC_W(ACC_W)) u_sat_x (
    .acc_cur (cur_x),
    .addend  (IN_FX),
    .acc_nxt (sum_x)
  );

  sat_add_acc #(.ACC_W(ACC_W)) u_sat_y (
    .acc_cur (cur_y),
    .addend  (IN_FY),
    .acc_nxt (sum_y)
  );

  // Index whose result gets registered onto the write port at this edge.
  // The edge that accepts IN_LAST loads entry 0; each FLUSH edge loads
  // the entry after the one currently on the port.
  assign fidx    = (state == FLUSH) ? flush_cnt + IDX_BITS'(1) : '0;
  assign fidx_ok = ({1'b0, fidx} < N_EXT);

  // The final beat may target entry 0 on the very edge that loads it,
  // so forward the freshly summed value rather than the stale array.
  always_comb begin
    fwd_x = '0;
    fwd_y = '0;
    if (fidx_ok) begin
      if (accept && idx_ok && (IN_IDX == fidx)) begin
        fwd_x = sum_x;
        fwd_y = sum_y;
      end else begin
        fwd_x = acc_x[fidx];
        fwd_y = acc_y[fidx];
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    clear_d       = 1'b0;
    wr_en_d       = 1'b0;
    frame_valid_d = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          state_nxt = CLR;
          clear_d   = 1'b1;
        end
      end
      CLR: begin
        state_nxt = ACCUM;
      end
      ACCUM: begin
        if (accept && IN_LAST) begin
          state_nxt = FLUSH;
          wr_en_d   = 1'b1;
        end
      end
      FLUSH: begin
        if (flush_cnt == LAST_IDX) begin
          state_nxt     = PUBLISH;
          frame_valid_d = 1'b1;
        end else begin
          wr_en_d = 1'b1;
        end
      end
      PUBLISH: begin
        if (BUF_DONE) begin
          state_nxt = IDLE;
        end else begin
          frame_valid_d = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      CLEAR       <= 1'b0;
      WR_EN       <= 1'b0;
      WR_IDX      <= '0;
      FORCE_X     <= '0;
      FORCE_Y     <= '0;
      FRAME_VALID <= 1'b0;
      BUSY        <= 1'b0;
      ERR         <= 1'b0;
      flush_cnt   <= '0;
      for (int i = 0; i < N; i++) begin
        acc_x[i] <= '0;
        acc_y[i] <= '0;
      end
    end else begin
      CLEAR       <= clear_d;
      WR_EN       <= wr_en_d;
      FRAME_VALID <= frame_valid_d;
      BUSY        <= (state_nxt != IDLE);

      if (wr_en_d) begin
        WR_IDX  <= fidx;
        FORCE_X <= sat16(SAT_IN_W'(fwd_x));
        FORCE_Y <= sat16(SAT_IN_W'(fwd_y));
      end

      if (state == FLUSH) begin
        flush_cnt <= flush_cnt + IDX_BITS'(1);
      end else begin
        flush_cnt <= '0;
      end

      // Zeroing happens on the edge entering CLR so the whole array is
      // clean by the first cycle of ACCUM.
      if (clear_d) begin
        ERR <= 1'b0;
        for (int i = 0; i < N; i++) begin
          acc_x[i] <= '0;
          acc_y[i] <= '0;
        end
      end else if (accept) begin
        if (idx_ok) begin
          acc_x[IN_IDX] <= sum_x;
          acc_y[IN_IDX] <= sum_y;
        end else begin
          ERR <= 1'b1;
        end
      end
    end
  end

endmodule
